// File: rtl/conv_arb_pkg.sv
// Shared state type and default sizing for the convolution output arbiter.
package conv_arb_pkg;

    localparam int DEF_OUTW  = 24;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_BURST = 8;

    typedef enum logic {
        StIdle,
        StBurst
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority search: first asserted req after index `last`, wrapping around.
module rr_priority_pick #(
    parameter int NREQ = 4,
    parameter int LOGN = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LOGN-1:0] last,
    output logic            found,
    output logic [LOGN-1:0] idx
);

    logic [LOGN-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Scan farthest-first so the nearest requester after `last` is the final winner.
        for (int k = NREQ; k >= 1; k--) begin
            cand = LOGN'((int'(last) + k) % NREQ);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/conv_out_arbiter.sv
// Round-robin burst arbiter merging NREQ lane FIFOs onto one registered AXI-stream port.
module conv_out_arbiter
    import conv_arb_pkg::*;
#(
    parameter int  OUTW  = DEF_OUTW,
    parameter int  NREQ  = DEF_NREQ,
    parameter int  BURST = DEF_BURST,
    localparam int LOGN  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ*OUTW-1:0] IN_AXIS_TDATA,
    input  logic [NREQ-1:0]      IN_AXIS_TVALID,
    output logic [NREQ-1:0]      IN_AXIS_TREADY,
    output logic [OUTW-1:0]      OUT_AXIS_TDATA,
    output logic                 OUT_AXIS_TVALID,
    output logic [LOGN-1:0]      OUT_AXIS_TID,
    output logic                 OUT_AXIS_TLAST,
    input  logic                 OUT_AXIS_TREADY
);

    localparam int              CNTW     = $clog2(BURST);
    localparam logic [CNTW-1:0] LastBeat = CNTW'(BURST - 1);

    arb_state_e      state_q, state_d;
    logic [LOGN-1:0] grant_q, grant_d;
    logic [LOGN-1:0] last_grant_q, last_grant_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [OUTW-1:0] data_q, data_d;
    logic [LOGN-1:0] tid_q, tid_d;
    logic            tlast_q, tlast_d;
    logic            valid_q, valid_d;

    logic            pick_found;
    logic [LOGN-1:0] pick_idx;
    logic            in_burst;
    logic            slot_open;
    logic            xfer;

    rr_priority_pick #(
        .NREQ (NREQ),
        .LOGN (LOGN)
    ) u_pick (
        .req   (IN_AXIS_TVALID),
        .last  (last_grant_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Ready depends only on state and the output slice, never on the lane valids.
    always_comb begin
        in_burst       = (state_q == StBurst);
        slot_open      = !valid_q || OUT_AXIS_TREADY;
        IN_AXIS_TREADY = '0;
        if (in_burst) begin
            IN_AXIS_TREADY[grant_q] = slot_open;
        end
        xfer = in_burst && slot_open && IN_AXIS_TVALID[grant_q];
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        data_d       = data_q;
        tid_d        = tid_q;
        tlast_d      = tlast_q;
        valid_d      = valid_q && !OUT_AXIS_TREADY;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    count_d = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (xfer) begin
                    data_d  = IN_AXIS_TDATA[int'(grant_q) * OUTW +: OUTW];
                    tid_d   = grant_q;
                    tlast_d = (count_q == LastBeat);
                    valid_d = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == LastBeat) begin
                        last_grant_d = grant_q;
                        state_d      = StIdle;
                    end
                end else if (slot_open) begin
                    // Granted lane ran dry: give the port up without a TLAST.
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= LOGN'(NREQ - 1);
            count_q      <= '0;
            data_q       <= '0;
            tid_q        <= '0;
            tlast_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            data_q       <= data_d;
            tid_q        <= tid_d;
            tlast_q      <= tlast_d;
            valid_q      <= valid_d;
        end
    end

    assign OUT_AXIS_TDATA  = data_q;
    assign OUT_AXIS_TVALID = valid_q;
    assign OUT_AXIS_TID    = tid_q;
    assign OUT_AXIS_TLAST  = tlast_q;

endmodule

// File: tb/tb_conv_out_arbiter.sv
// Directed and random bench for conv_out_arbiter with an input-handshake scoreboard.
module tb_conv_out_arbiter;

    localparam int OUTW  = 24;
    localparam int NREQ  = 4;
    localparam int BURST = 4;
    localparam int LOGN  = 2;

    typedef struct {
        logic [LOGN-1:0] tid;
        logic [OUTW-1:0] data;
    } beat_t;

    logic                 clk;
    logic                 reset;
    logic [NREQ*OUTW-1:0] in_tdata;
    logic [NREQ-1:0]      in_tvalid;
    logic [NREQ-1:0]      in_tready;
    logic [OUTW-1:0]      out_tdata;
    logic                 out_tvalid;
    logic [LOGN-1:0]      out_tid;
    logic                 out_tlast;
    logic                 out_tready;

    int n_checks, n_pass, n_fail;
    int lane_left[NREQ];
    int lane_seq[NREQ];
    int next_out[NREQ];
    beat_t           exp_q[$];
    logic [LOGN-1:0] obs_tid[$];
    logic            obs_last[$];
    logic [OUTW-1:0] obs_data[$];
    logic            vpat[$];
    logic            rpat[$];

    conv_out_arbiter #(
        .OUTW  (OUTW),
        .NREQ  (NREQ),
        .BURST (BURST)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .IN_AXIS_TDATA   (in_tdata),
        .IN_AXIS_TVALID  (in_tvalid),
        .IN_AXIS_TREADY  (in_tready),
        .OUT_AXIS_TDATA  (out_tdata),
        .OUT_AXIS_TVALID (out_tvalid),
        .OUT_AXIS_TID    (out_tid),
        .OUT_AXIS_TLAST  (out_tlast),
        .OUT_AXIS_TREADY (out_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [OUTW-1:0] lane_word(input int lane, input int seq);
        return {8'(lane), 16'(seq)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resync();
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) next_out[i] = lane_seq[i];
    endtask

    task automatic clear_logs();
        obs_tid.delete();
        obs_last.delete();
        obs_data.delete();
        vpat.delete();
        rpat.delete();
    endtask

    // One clock: present lane heads, score handshakes due at the next edge, advance.
    task automatic tick();
        logic [NREQ-1:0] hs;
        beat_t           b;
        beat_t           e;
        int              lane;
        hs = '0;
        for (int i = 0; i < NREQ; i++) begin
            in_tvalid[i]                = (lane_left[i] > 0);
            in_tdata[i*OUTW +: OUTW]    = lane_word(i, lane_seq[i]);
        end
        #1;
        vpat.push_back(out_tvalid);
        rpat.push_back(|in_tready);
        if (reset === 1'b1) begin
            check("rdy_onehot", 32'($countones(in_tready) <= 1), 32'd1);
        end
        if (out_tvalid === 1'b1 && out_tready) begin
            obs_tid.push_back(out_tid);
            obs_last.push_back(out_tlast);
            obs_data.push_back(out_tdata);
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_data", 32'(out_tdata), 32'(e.data));
                check("sb_tid", 32'(out_tid), 32'(e.tid));
            end
            lane = int'(out_tdata[23:16]);
            check("tid_lane", 32'(out_tid), 32'(lane));
            if (lane < NREQ) begin
                check("lane_order", 32'(out_tdata[15:0]), 32'(next_out[lane]));
                next_out[lane] = int'(out_tdata[15:0]) + 1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (in_tready[i] === 1'b1 && in_tvalid[i]) begin
                hs[i]  = 1'b1;
                b.tid  = LOGN'(i);
                b.data = lane_word(i, lane_seq[i]);
                exp_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                lane_seq[i]++;
                lane_left[i]--;
            end
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        out_tready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            lane_left[i] = 0;
            lane_seq[i]  = 0;
        end
        repeat (2) tick();
        reset = 1'b1;
        resync();
        clear_logs();
    endtask

    initial begin
        int exp3[4];
        int total;
        exp3 = '{3, 3, 1, 1};
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        in_tdata  = '0;
        in_tvalid = '0;

        // Reset values
        do_reset();
        check("rst_tvalid", 32'(out_tvalid), 32'd0);
        check("rst_tdata", 32'(out_tdata), 32'd0);
        check("rst_tid", 32'(out_tid), 32'd0);
        check("rst_tlast", 32'(out_tlast), 32'd0);
        check("rst_tready", 32'(in_tready), 32'd0);

        // Full load: round robin from lane 0, TLAST every 4th beat, one bubble per grant
        for (int i = 0; i < NREQ; i++) lane_left[i] = 1000;
        repeat (45) tick();
        check("lat_rdy_t0", 32'(rpat[0]), 32'd0);
        check("lat_rdy_t1", 32'(rpat[1]), 32'd1);
        check("lat_valid_t1", 32'(vpat[1]), 32'd0);
        for (int k = 0; k < 20; k++) begin
            check("bubble_pattern", 32'(vpat[2+k]), 32'((k % 5) != 4));
        end
        check("full_beats", 32'(obs_tid.size() >= 20), 32'd1);
        for (int n = 0; n < 20 && n < obs_tid.size(); n++) begin
            check("rr_tid", 32'(obs_tid[n]), 32'((n / 4) % 4));
            check("rr_last", 32'(obs_last[n]), 32'((n % 4) == 3));
        end
        for (int i = 0; i < NREQ; i++) lane_left[i] = 0;
        repeat (8) tick();
        check("full_drain", 32'(exp_q.size()), 32'd0);

        // Lone lane 2, two beats then empty: early release, then re-grant
        do_reset();
        lane_left[2] = 2;
        repeat (8) tick();
        check("lone_count", 32'(obs_tid.size()), 32'd2);
        for (int n = 0; n < 2 && n < obs_tid.size(); n++) begin
            check("lone_tid", 32'(obs_tid[n]), 32'd2);
            check("lone_nolast", 32'(obs_last[n]), 32'd0);
        end
        check("lone_idle", 32'(in_tready), 32'd0);
        clear_logs();
        lane_left[2] = 1;
        tick();
        check("lone_regrant", 32'(in_tready), 32'b0100);
        repeat (6) tick();
        check("lone_regrant_beats", 32'(obs_tid.size()), 32'd1);
        if (obs_tid.size() > 0) check("lone_regrant_tid", 32'(obs_tid[0]), 32'd2);

        // last_grant = 1, lanes 1 and 3 together: lane 3 wins first
        do_reset();
        lane_left[1] = 1;
        repeat (6) tick();
        clear_logs();
        lane_left[1] = 2;
        lane_left[3] = 2;
        repeat (14) tick();
        check("rot_count", 32'(obs_tid.size()), 32'd4);
        for (int n = 0; n < 4 && n < obs_tid.size(); n++) begin
            check("rot_tid", 32'(obs_tid[n]), 32'(exp3[n]));
        end

        // Downstream stall mid-burst holds the slice and blocks the lane
        do_reset();
        lane_left[0] = 100;
        repeat (3) tick();
        out_tready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_data", 32'(out_tdata), 32'h000001);
            check("stall_tid", 32'(out_tid), 32'd0);
            check("stall_tlast", 32'(out_tlast), 32'd0);
            check("stall_tvalid", 32'(out_tvalid), 32'd1);
            check("stall_tready", 32'(in_tready), 32'd0);
        end
        out_tready = 1'b1;
        repeat (4) tick();
        check("stall_beats", 32'(obs_tid.size() >= 4), 32'd1);
        for (int n = 0; n < 4 && n < obs_last.size(); n++) begin
            check("stall_last", 32'(obs_last[n]), 32'(n == 3));
        end
        if (obs_data.size() >= 4) check("stall_beat4", 32'(obs_data[3]), 32'h000003);
        lane_left[0] = 0;
        repeat (8) tick();
        check("stall_drain", 32'(exp_q.size()), 32'd0);

        // Reset during beat 2 of a lane-1 burst
        do_reset();
        lane_left[1] = 100;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("mid_rst_tvalid", 32'(out_tvalid), 32'd0);
        check("mid_rst_tready", 32'(in_tready), 32'd0);
        resync();
        lane_left[0] = 3;
        reset = 1'b1;
        tick();
        check("mid_rst_lane0", 32'(in_tready), 32'b0001);
        for (int i = 0; i < NREQ; i++) lane_left[i] = 0;
        repeat (10) tick();
        check("mid_rst_drain", 32'(exp_q.size()), 32'd0);

        // Random valid/ready traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            out_tready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (lane_left[i] == 0 && $urandom_range(0, 7) == 0) begin
                    lane_left[i] = int'($urandom_range(1, 10));
                end
            end
            tick();
        end
        out_tready = 1'b1;
        repeat (80) tick();
        check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            check("rand_lane_done", 32'(next_out[i]), 32'(lane_seq[i]));
            check("rand_lane_empty", 32'(lane_left[i]), 32'd0);
            total += lane_seq[i];
        end
        check("rand_traffic", 32'(total > 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_out_arbiter.md
# conv_out_arbiter

Round-robin scheduler that shares one output AXI-stream port between NREQ convolution-lane output FIFOs. It grants one lane at a time for a burst of up to BURST beats, tags each beat with the source lane, and marks full-burst ends with TLAST. It sits between the per-lane output FIFOs and the single result stream toward the host DMA.

## Interface
- OUTW, 24, data width per beat (matches lane FIFO width)
- NREQ, 4, number of requesting lanes (>= 2)
- BURST, 8, maximum beats per grant (>= 2)
- LOGN, $clog2(NREQ), localparam, lane-index width
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-low; one clock; reset is synchronous and active-low
- IN_AXIS_TDATA  input  NREQ*OUTW  packed lane data; lane i at [i*OUTW +: OUTW]
- IN_AXIS_TVALID  input  NREQ  per-lane valid (lane FIFO not empty)
- IN_AXIS_TREADY  output  NREQ  per-lane ready; at most one bit high
- OUT_AXIS_TDATA  output  OUTW  registered output beat
- OUT_AXIS_TVALID  output  1  registered valid
- OUT_AXIS_TID  output  LOGN  source lane of current beat
- OUT_AXIS_TLAST  output  1  high on the BURST-th beat of a grant
- OUT_AXIS_TREADY  input  1  downstream ready

## Operation
- FSM states: IDLE, BURST.
- Registers: state, grant (LOGN), last_grant (LOGN), beat count (clog2(BURST)), output slice (data, tid, tlast, valid).
- IDLE: if any IN_AXIS_TVALID bit is high, grant = first valid lane searching from (last_grant+1) mod NREQ upward with wrap; count <= 0; go to BURST. No valid lanes: remain in IDLE.
- BURST: slot_open = !OUT_AXIS_TVALID || OUT_AXIS_TREADY. IN_AXIS_TREADY[grant] = slot_open; all other bits 0. IN_AXIS_TREADY is all-zero in IDLE.
- Transfer when IN_AXIS_TVALID[grant] && IN_AXIS_TREADY[grant]: the output slice loads the data, tid = grant, tlast = (count == BURST-1), valid = 1; count increments.
- Transfer with count == BURST-1: last_grant <= grant, go to IDLE.
- slot_open && !IN_AXIS_TVALID[grant] (lane drained): early release. last_grant <= grant, go to IDLE, no TLAST is emitted.
- slot_open with no transfer: OUT_AXIS_TVALID clears once the held beat is taken.
- OUT_AXIS_TVALID && !OUT_AXIS_TREADY: the slice holds data, tid and tlast stable; no transfer; count frozen.
- Both lanes and downstream continuously ready: bursts back to back with exactly one IDLE bubble cycle between grants.
- A lane that is the only requester is re-granted after each bubble.
- Reset mid-burst: in-flight slice beat is discarded. Upstream lanes never saw a handshake on any later beat, so no data is lost upstream.

## Timing
- Reset values: state IDLE, last_grant NREQ-1 (first grant goes to lane 0), count 0, OUT_AXIS_TVALID 0, OUT_AXIS_TDATA 0, OUT_AXIS_TID 0, OUT_AXIS_TLAST 0, IN_AXIS_TREADY 0.
- Arbitration latency: lane valid in IDLE at cycle t → IN_AXIS_TREADY high at t+1.
- Data latency: input handshake at t → OUT_AXIS_TVALID with that beat at t+1.
- Throughput: BURST beats per BURST+1 cycles under full load.
- IN_AXIS_TREADY is combinational from state, grant, OUT_AXIS_TVALID and OUT_AXIS_TREADY. It has no dependency on IN_AXIS_TVALID.

## Structure
- Package conv_arb_pkg holds:
  - the state enum typedef (IDLE, BURST)
  - the default OUTW, NREQ and BURST constants shared with the accelerator top.
- One sub-module, rr_priority_pick: combinational; inputs req[NREQ] and last[LOGN]; outputs found and idx[LOGN] (rotating-priority search).

## Test plan
- NREQ=4, BURST=4, all lanes always valid, OUT_AXIS_TREADY=1 → TID sequence 0×4,1×4,2×4,3×4,0…; TLAST on every 4th beat; one idle cycle between bursts.
- Only lane 2 valid, 2 beats then empty → 2 beats with TID=2 and no TLAST; state returns to IDLE; a later lane-2 request is re-granted to lane 2.
- last_grant=1, lanes 1 and 3 valid together → lane 3 granted first, then lane 1.
- OUT_AXIS_TREADY low for 3 cycles mid-burst → TDATA, TID and TLAST held stable; IN_AXIS_TREADY=0; count unchanged. On release, the remaining beats complete with TLAST on beat 4.
- reset driven low during beat 2 of a lane-1 burst → the next cycle shows OUT_AXIS_TVALID=0 and IN_AXIS_TREADY=0. After reset returns high, lane 0 is granted first.
- Random valid/ready, lane data = {lane, seq} → scoreboard: every beat delivered once, in order per lane, with the correct TID. IN_AXIS_TREADY is never high on more than one lane and never high on a lane without the grant.
